// File: rtl/vga_fb_arbiter_if.sv
// Host write port and framebuffer RAM port of vga_fb_arbiter.
// The arbiter connects to the slave modport. The host and RAM side connects to the master modport.
interface vga_fb_arbiter_if #(
    parameter int G_ADDR_W = 19,
    parameter int G_DATA_W = 8
);
    // host write channel
    logic                i_wr_valid;
    logic                o_wr_ready;
    logic [G_ADDR_W-1:0] i_wr_addr;
    logic [G_DATA_W-1:0] i_wr_data;
    logic                o_wr_err;

    // single-port framebuffer RAM
    logic                o_mem_en;
    logic                o_mem_we;
    logic [G_ADDR_W-1:0] o_mem_addr;
    logic [G_DATA_W-1:0] o_mem_wdata;
    logic [G_DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_wr_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_wr_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the pixel refresh path and a host write port.
//   - During the active region, display reads always win.
//   - Host writes wait in a small FIFO and drain one per blanking cycle.
//   - Writes whose address falls outside the frame are dropped, and each drop raises a one-cycle o_wr_err pulse.
// Optional build macro FBARB_STALL_CNT_EN enables o_stall_cnt.
//   - When enabled, the counter saturates. It counts the active cycles during which the FIFO held pending writes.
//   - When the macro is not defined, o_stall_cnt is tied to 0.
module vga_fb_arbiter #(
    parameter int G_H_RES      = 640,
    parameter int G_V_RES      = 480,
    parameter int G_ADDR_W     = 19,
    parameter int G_DATA_W     = 8,
    parameter int G_FIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [9:0]                        i_x,
    input  logic [9:0]                        i_y,
    input  logic                              i_active,
    vga_fb_arbiter_if.slave                   bus,
    output logic [G_DATA_W-1:0]               o_pix,
    output logic                              o_pix_valid,
    output logic [$clog2(G_FIFO_DEPTH):0]     o_fifo_level,
    output logic [15:0]                       o_stall_cnt
);

    localparam int PTR_W = $clog2(G_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [G_ADDR_W:0]  FB_SIZE  = (G_ADDR_W+1)'(G_H_RES * G_V_RES);
    localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(G_FIFO_DEPTH);
    // Latency from the x/y sample to o_pix: address register, RAM read, then the pixel register.
    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_DISP  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    typedef struct packed {
        logic [G_ADDR_W-1:0] addr;
        logic [G_DATA_W-1:0] data;
    } wr_entry_t;

    // FIFO state
    wr_entry_t          fifo_q [G_FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ready_q;
    logic               push, pop;
    wr_entry_t          head;
    logic               head_ok;

    // RAM-side and FSM state
    state_e             state_q;
    logic               mem_en_q;
    logic [G_ADDR_W-1:0] mem_addr_q;
    logic [G_DATA_W-1:0] mem_wdata_q;
    logic               wr_err_q;
    logic [G_ADDR_W-1:0] disp_addr;

    // Display pipeline state
    logic [STAGES-1:0]  vld_pipe;
    logic [G_DATA_W-1:0] pix_q;

    // Handshake, FIFO bookkeeping and display address.
    // Only registered occupancy is used here, so the FIFO has no same-cycle bypass.
    always_comb begin
        push    = bus.i_wr_valid && ready_q;
        pop     = !i_active && (level_q != '0);
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LVL_W'(1);
        else if (!push && pop)
            level_d = level_q - LVL_W'(1);
        head    = fifo_q[rptr_q];
        head_ok = {1'b0, head.addr} < FB_SIZE;
        // The low G_ADDR_W bits of y*H+x depend only on the low bits of the operands.
        // Computing at G_ADDR_W width therefore equals computing at full width and then truncating.
        disp_addr = G_ADDR_W'(i_y) * G_ADDR_W'(G_H_RES) + G_ADDR_W'(i_x);
    end

    // FSM: picks this cycle's RAM operation from i_active and FIFO emptiness. Every RAM output is registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_BLANK;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            wr_err_q <= 1'b0;
            if (i_active) begin
                // A read is never preempted, including on the first active cycle.
                state_q    <= S_DISP;
                mem_en_q   <= 1'b1;
                mem_addr_q <= disp_addr;
            end else if (level_q != '0) begin
                // Pop the head entry. An out-of-frame entry is consumed but not written.
                state_q     <= S_WRITE;
                mem_en_q    <= head_ok;
                wr_err_q    <= !head_ok;
                mem_addr_q  <= head.addr;
                mem_wdata_q <= head.data;
            end else begin
                state_q  <= S_BLANK;
                mem_en_q <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and registered ready. A reset discards every queued write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ready_q <= (level_d != LVL_FULL);
        end
    end

    // FIFO storage. It needs no reset because the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push)
            fifo_q[wptr_q] <= '{addr: bus.i_wr_addr, data: bus.i_wr_data};
    end

    // Display pipeline.
    //   - The active flag travels with the read through address, RAM and pixel stages.
    //   - The pixel is zeroed outside the visible region.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            pix_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], i_active};
            pix_q    <= vld_pipe[STAGES-2] ? bus.i_mem_rdata : '0;
        end
    end

`ifdef FBARB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Stall statistic: counts each cycle that a read is issued while host writes are pending. It saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            stall_q <= '0;
        else if (i_active && (level_q != '0) && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

    assign bus.o_wr_ready  = ready_q;
    assign bus.o_wr_err    = wr_err_q;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_we    = mem_en_q && (state_q == S_WRITE);
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign o_pix           = pix_q;
    assign o_pix_valid     = vld_pipe[STAGES-1];
    assign o_fifo_level    = level_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter.
// The bench uses a table of display read vectors and hand-written write/blanking sequences.
// Two scoreboards are checked by a negedge monitor: expected pixels and expected RAM writes/drops.
module tb_vga_fb_arbiter;
    localparam int H = 640, V = 480, AW = 19, DW = 8, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    x = '0, y = '0;
    logic          active = 1'b0;
    logic [DW-1:0] pix;
    logic          pix_valid;
    logic [2:0]    level;
    logic [15:0]   stall;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    vga_fb_arbiter_if #(.G_ADDR_W(AW), .G_DATA_W(DW)) bus();

    vga_fb_arbiter #(
        .G_H_RES(H), .G_V_RES(V), .G_ADDR_W(AW), .G_DATA_W(DW), .G_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_active(active),
        .bus(bus), .o_pix(pix), .o_pix_valid(pix_valid),
        .o_fifo_level(level), .o_stall_cnt(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          bad;
    } wr_exp_t;

    typedef struct {
        logic [9:0]    vx;
        logic [9:0]    vy;
        logic [AW-1:0] exp_addr;
    } disp_vec_t;

    wr_exp_t       wr_q[$];
    logic [DW-1:0] pix_q[$];
    logic [2:0]    act_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_addr(input logic [9:0] xx, input logic [9:0] yy);
        int a;
        a = int'(yy) * H + int'(xx);
        return AW'(a % (1 << AW));
    endfunction

    // RAM model: a registered read that returns the low bits of the address.
    always @(posedge clk) begin
        if (rst)
            bus.i_mem_rdata <= '0;
        else if (bus.o_mem_en && !bus.o_mem_we)
            bus.i_mem_rdata <= bus.o_mem_addr[DW-1:0];
    end

    // Reference pipeline: one expected pixel is produced per active cycle, and the active history is recorded.
    always @(posedge clk) begin
        logic [AW-1:0] a;
        if (rst) begin
            pix_q.delete();
            wr_q.delete();
            act_hist <= '0;
        end else begin
            act_hist <= {act_hist[1:0], active};
            if (active) begin
                a = model_addr(x, y);
                pix_q.push_back(a[DW-1:0]);
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        wr_exp_t       w;
        logic [DW-1:0] e;
        if (mon_en && !rst) begin
            check("pix_valid_delay", {31'b0, pix_valid}, {31'b0, act_hist[2]});
            if (pix_valid) begin
                if (pix_q.size() == 0) check("pix_unexpected", 32'd1, 32'd0);
                else begin
                    e = pix_q.pop_front();
                    check("pix_data", {24'b0, pix}, {24'b0, e});
                end
            end else
                check("pix_idle_zero", {24'b0, pix}, 32'd0);
            check("read_issue", {31'b0, bus.o_mem_en && !bus.o_mem_we}, {31'b0, act_hist[0]});
            if (bus.o_mem_we || bus.o_wr_err) begin
                check("we_err_exclusive", {31'b0, bus.o_mem_we && bus.o_wr_err}, 32'd0);
                if (wr_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    check("write_kind_bad", {31'b0, bus.o_wr_err}, {31'b0, w.bad});
                    check("write_en", {31'b0, bus.o_mem_en}, {31'b0, !w.bad});
                    if (!w.bad) begin
                        check("write_addr", {13'b0, bus.o_mem_addr}, {13'b0, w.addr});
                        check("write_data", {24'b0, bus.o_mem_wdata}, {24'b0, w.data});
                    end
                end
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic bad);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        check("wr_ready_before_push", {31'b0, bus.o_wr_ready}, 32'd1);
        wr_q.push_back('{addr: a, data: d, bad: bad});
        step();
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        active = 1'b0;
        bus.i_wr_valid = 1'b0;
        step();
        check("rst_ready", {31'b0, bus.o_wr_ready}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        check("rst_mem_en", {31'b0, bus.o_mem_en}, 32'd0);
        check("rst_wr_err", {31'b0, bus.o_wr_err}, 32'd0);
        check("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
        check("rst_stall", {16'b0, stall}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", {31'b0, bus.o_wr_ready}, 32'd1);
        check("post_rst_level", {29'b0, level}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        disp_vec_t vecs[7];
        int exp_stall;

        vecs[0] = '{vx: 10'd5,    vy: 10'd2,    exp_addr: 19'd1285};
        vecs[1] = '{vx: 10'd0,    vy: 10'd0,    exp_addr: 19'd0};
        vecs[2] = '{vx: 10'd639,  vy: 10'd479,  exp_addr: 19'd307199};
        vecs[3] = '{vx: 10'd639,  vy: 10'd0,    exp_addr: 19'd639};
        vecs[4] = '{vx: 10'd0,    vy: 10'd479,  exp_addr: 19'd306560};
        vecs[5] = '{vx: 10'd100,  vy: 10'd100,  exp_addr: 19'd64100};
        vecs[6] = '{vx: 10'd1023, vy: 10'd1023, exp_addr: 19'd131455};

        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        step();
        step();
        mon_en = 1'b1;
        rst = 1'b0;
        step();

        // Reset with three queued writes. The queued writes are discarded and never reach the RAM.
        active = 1'b1;
        host_write(19'd11, 8'h11, 1'b0);
        host_write(19'd12, 8'h12, 1'b0);
        host_write(19'd13, 8'h13, 1'b0);
        check("t1_level3", {29'b0, level}, 32'd3);
        do_reset();
        repeat (5) step();
        check("t1_level_after", {29'b0, level}, 32'd0);

        // Display read address table
        active = 1'b1;
        for (int i = 0; i < 7; i++) begin
            x = vecs[i].vx;
            y = vecs[i].vy;
            step();
            check("disp_addr", {13'b0, bus.o_mem_addr}, {13'b0, vecs[i].exp_addr});
            check("disp_en", {31'b0, bus.o_mem_en}, 32'd1);
            check("disp_we", {31'b0, bus.o_mem_we}, 32'd0);
        end
        active = 1'b0;
        x = '0;
        y = '0;
        repeat (5) step();

        // Fill the FIFO during active. It must not drain until blanking, then drains in order.
        do_reset();
        active = 1'b1;
        host_write(19'd100, 8'hA1, 1'b0);
        host_write(19'd200, 8'hA2, 1'b0);
        host_write(19'd300, 8'hA3, 1'b0);
        host_write(19'd400, 8'hA4, 1'b0);
        check("full_ready", {31'b0, bus.o_wr_ready}, 32'd0);
        check("full_level", {29'b0, level}, 32'd4);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 19'd500;
        bus.i_wr_data  = 8'hEE;
        step();
        bus.i_wr_valid = 1'b0;
        check("full_no_push", {29'b0, level}, 32'd4);
        step();
        step();
        active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_we", {31'b0, bus.o_mem_we}, 32'd1);
            check("drain_level", {29'b0, level}, 32'(3 - i));
        end
        step();
        check("drain_done_we", {31'b0, bus.o_mem_we}, 32'd0);
        check("drain_done_ready", {31'b0, bus.o_wr_ready}, 32'd1);

        // An out-of-range write during blanking is dropped and raises a one-cycle pulse.
        host_write(19'd307200, 8'h55, 1'b1);
        check("bad_level_pushed", {29'b0, level}, 32'd1);
        check("bad_no_err_yet", {31'b0, bus.o_wr_err}, 32'd0);
        step();
        check("bad_err_pulse", {31'b0, bus.o_wr_err}, 32'd1);
        check("bad_mem_en", {31'b0, bus.o_mem_en}, 32'd0);
        check("bad_level_pop", {29'b0, level}, 32'd0);
        step();
        check("bad_err_single", {31'b0, bus.o_wr_err}, 32'd0);

        // Two bad entries back to back, then one good entry at the top address of the frame.
        active = 1'b1;
        host_write(19'd307200, 8'h01, 1'b1);
        host_write(19'd524287, 8'h02, 1'b1);
        host_write(19'd307199, 8'h77, 1'b0);
        check("b2b_level", {29'b0, level}, 32'd3);
        active = 1'b0;
        step();
        check("b2b_err1", {31'b0, bus.o_wr_err}, 32'd1);
        step();
        check("b2b_err2", {31'b0, bus.o_wr_err}, 32'd1);
        step();
        check("b2b_good_we", {31'b0, bus.o_mem_we}, 32'd1);
        check("b2b_good_err", {31'b0, bus.o_wr_err}, 32'd0);
        step();

        // A pending write when active rises: the read wins, and the write waits for blanking.
        do_reset();
        host_write(19'd1234, 8'h3C, 1'b0);
        active = 1'b1;
        check("defer_level", {29'b0, level}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("defer_read_en", {31'b0, bus.o_mem_en}, 32'd1);
            check("defer_read_we", {31'b0, bus.o_mem_we}, 32'd0);
            check("defer_level_held", {29'b0, level}, 32'd1);
        end
        active = 1'b0;
        step();
        check("defer_write_we", {31'b0, bus.o_mem_we}, 32'd1);
        check("defer_write_addr", {13'b0, bus.o_mem_addr}, 32'd1234);
        check("defer_level_zero", {29'b0, level}, 32'd0);
`ifdef FBARB_STALL_CNT_EN
        exp_stall = 4;
`else
        exp_stall = 0;
`endif
        step();
        check("stall_count", {16'b0, stall}, 32'(exp_stall));

        // Push and pop in the same cycle at level 2
        active = 1'b1;
        host_write(19'd10, 8'h01, 1'b0);
        host_write(19'd20, 8'h02, 1'b0);
        check("pp_level2", {29'b0, level}, 32'd2);
        active = 1'b0;
        host_write(19'd30, 8'h03, 1'b0);
        check("pp_level_keep1", {29'b0, level}, 32'd2);
        host_write(19'd307199, 8'h04, 1'b0);
        check("pp_level_keep2", {29'b0, level}, 32'd2);
        step();
        check("pp_level1", {29'b0, level}, 32'd1);
        step();
        check("pp_level0", {29'b0, level}, 32'd0);

        repeat (6) step();
        check("sb_writes_empty", 32'(wr_q.size()), 32'd0);
        check("sb_pix_empty", 32'(pix_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
